clk_div_period_checker: RTL and testbench

//  Receive-side checker for divided clocks produced by the clk_int_*_div family.

---
 rtl/clk_div_period_checker_if.sv | 28 ++
 rtl/clk_div_period_checker.sv | 167 ++++++++++++++++
 tb/tb_clk_div_period_checker.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_div_period_checker_if.sv
// Signal bundle between a divided-clock source/bench and the period checker.
// The master side drives the clock under test and expectations; the slave side is the checker.
interface clk_div_period_checker_if #(
  parameter int CNT_WIDTH = 8,
  parameter int ERR_WIDTH = 8
);
  logic                 en_i;
  logic                 div_clk_i;
  logic [CNT_WIDTH-1:0] exp_period_i;
  logic [CNT_WIDTH-1:0] exp_high_i;
  logic                 clr_err_i;
  logic [CNT_WIDTH-1:0] period_o;
  logic [CNT_WIDTH-1:0] high_o;
  logic                 meas_valid_o;
  logic                 locked_o;
  logic                 err_o;
  logic [ERR_WIDTH-1:0] err_cnt_o;

  modport master (
    output en_i, div_clk_i, exp_period_i, exp_high_i, clr_err_i,
    input  period_o, high_o, meas_valid_o, locked_o, err_o, err_cnt_o
  );

  modport slave (
    input  en_i, div_clk_i, exp_period_i, exp_high_i, clr_err_i,
    output period_o, high_o, meas_valid_o, locked_o, err_o, err_cnt_o
  );
endinterface

// File: rtl/clk_div_period_checker.sv
// Receive-side checker for divided clocks: samples div_clk_i in the clk_i domain, measures
// period/high time, compares to expectations and reports lock, sticky errors and an error count.
module clk_div_period_checker #(
  parameter int CNT_WIDTH   = 8,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4,
  parameter int ERR_WIDTH   = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  clk_div_period_checker_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, WAIT_EDGE, MEASURE, LOCKED} state_e;

  localparam int MATCH_W = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
  localparam logic [MATCH_W-1:0]   MATCH_LAST  = MATCH_W'(LOCK_COUNT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_PRE_SAT = {{(CNT_WIDTH-1){1'b1}}, 1'b0};

  function automatic logic [CNT_WIDTH-1:0] sat_inc_cnt(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  function automatic logic [ERR_WIDTH-1:0] sat_inc_err(input logic [ERR_WIDTH-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  state_e                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   sync_d_p1;
  logic                   rise_p1, fall_p1;
  logic [CNT_WIDTH-1:0]   cnt, hi_q;
  logic [MATCH_W-1:0]     match_cnt, match_nxt;
  logic                   is_match, timeout, err_evt, meas_vld_p1;

  // Synchronizer and edge detect: edges appear SYNC_STAGES+1 cycles after the input edge
  assign rise_p1 =  sync_p0[SYNC_STAGES-1] & ~sync_d_p1;
  assign fall_p1 = ~sync_p0[SYNC_STAGES-1] &  sync_d_p1;

  assign is_match = (cnt == bus.exp_period_i) && (hi_q == bus.exp_high_i);
  // A stuck clock is flagged once: only on the step into saturation
  assign timeout  = (state != IDLE) && !rise_p1 && (cnt == CNT_PRE_SAT);

  always_comb begin
    state_nxt   = state;
    match_nxt   = match_cnt;
    err_evt     = 1'b0;
    meas_vld_p1 = 1'b0;
    if (!bus.en_i) begin
      state_nxt = IDLE;
      match_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = WAIT_EDGE;
          match_nxt = '0;
        end
        WAIT_EDGE: begin
          if (rise_p1) begin
            state_nxt = MEASURE;
          end else if (timeout) begin
            err_evt = 1'b1;
          end
        end
        MEASURE: begin
          if (rise_p1) begin
            meas_vld_p1 = 1'b1;
            if (is_match) begin
              if (match_cnt == MATCH_LAST) begin
                state_nxt = LOCKED;
                match_nxt = '0;
              end else begin
                match_nxt = match_cnt + 1'b1;
              end
            end else begin
              match_nxt = '0;
              err_evt   = 1'b1;
            end
          end else if (timeout) begin
            state_nxt = WAIT_EDGE;
            match_nxt = '0;
            err_evt   = 1'b1;
          end
        end
        LOCKED: begin
          if (rise_p1) begin
            meas_vld_p1 = 1'b1;
            if (!is_match) begin
              state_nxt = MEASURE;
              match_nxt = '0;
              err_evt   = 1'b1;
            end
          end else if (timeout) begin
            state_nxt = WAIT_EDGE;
            match_nxt = '0;
            err_evt   = 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          match_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      match_cnt <= '0;
      sync_p0   <= '0;
      sync_d_p1 <= 1'b0;
    end else begin
      state     <= state_nxt;
      match_cnt <= match_nxt;
      sync_p0   <= {sync_p0[SYNC_STAGES-2:0], bus.div_clk_i};
      sync_d_p1 <= sync_p0[SYNC_STAGES-1];
    end
  end

  // Measurement counters: cnt restarts at 1 on each rise, hi_q captures cnt at the fall
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt  <= '0;
      hi_q <= '0;
    end else begin
      if (!bus.en_i || state == IDLE) begin
        cnt <= '0;
      end else if (rise_p1) begin
        cnt <= CNT_WIDTH'(1);
      end else begin
        cnt <= sat_inc_cnt(cnt);
      end
      if (fall_p1) begin
        hi_q <= cnt;
      end
    end
  end

  // Result and status registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bus.period_o     <= '0;
      bus.high_o       <= '0;
      bus.meas_valid_o <= 1'b0;
      bus.locked_o     <= 1'b0;
      bus.err_o        <= 1'b0;
      bus.err_cnt_o    <= '0;
    end else begin
      bus.meas_valid_o <= meas_vld_p1;
      bus.locked_o     <= (state_nxt == LOCKED);
      if (meas_vld_p1) begin
        bus.period_o <= cnt;
        bus.high_o   <= hi_q;
      end
      // A new error outranks a coincident clear, restarting the count at 1
      if (err_evt) begin
        bus.err_o     <= 1'b1;
        bus.err_cnt_o <= bus.clr_err_i ? ERR_WIDTH'(1) : sat_inc_err(bus.err_cnt_o);
      end else if (bus.clr_err_i) begin
        bus.err_o     <= 1'b0;
        bus.err_cnt_o <= '0;
      end
    end
  end

endmodule

// File: tb/tb_clk_div_period_checker.sv
// Scoreboard bench for clk_div_period_checker: a period-level model predicts each measurement
// record; a negedge monitor pops and compares whenever meas_valid_o pulses.
module tb_clk_div_period_checker;
  localparam int LOCK_N = 4;

  logic clk;
  logic rst;

  clk_div_period_checker_if #(.CNT_WIDTH(8), .ERR_WIDTH(8)) bus ();

  clk_div_period_checker #(
    .CNT_WIDTH(8), .SYNC_STAGES(2), .LOCK_COUNT(LOCK_N), .ERR_WIDTH(8)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int period;
    int high;
    bit locked;
    bit err;
    int err_cnt;
  } meas_t;

  meas_t sb_q[$];
  int    n_chk  = 0;
  int    n_pass = 0;

  // Period-level reference model state
  bit    m_en       = 1'b1;
  bit    have_prev  = 1'b0;
  int    prev_p     = 0;
  int    prev_h     = 0;
  int    streak     = 0;
  bit    m_err      = 1'b0;
  int    m_err_cnt  = 0;
  int    e_p        = 4;
  int    e_h        = 2;
  bit    en_q       = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
  endtask

  task automatic set_exp(input int p, input int h);
    e_p = p;
    e_h = h;
    bus.exp_period_i = 8'(p);
    bus.exp_high_i   = 8'(h);
  endtask

  task automatic set_en(input bit v);
    m_en = v;
    bus.en_i = v;
    if (!v) streak = 0;
  endtask

  task automatic model_error();
    m_err = 1'b1;
    if (m_err_cnt < 255) m_err_cnt++;
  endtask

  // Starts a new div_clk period (its rise closes the previous one); clr pulses with the result
  task automatic drive_period(input int p, input int h, input bit clr);
    meas_t rec;
    bit    evt;
    bit    res;
    evt = 1'b0;
    res = m_en && have_prev;
    if (res) begin
      if (prev_p == e_p && prev_h == e_h) streak++;
      else begin
        streak = 0;
        evt = 1'b1;
      end
    end
    if (evt) begin
      if (clr) begin
        m_err = 1'b1;
        m_err_cnt = 1;
      end else model_error();
    end else if (clr) begin
      m_err = 1'b0;
      m_err_cnt = 0;
    end
    if (res) begin
      rec.period  = prev_p;
      rec.high    = prev_h;
      rec.locked  = (streak >= LOCK_N);
      rec.err     = m_err;
      rec.err_cnt = m_err_cnt;
      sb_q.push_back(rec);
    end
    have_prev = m_en;
    prev_p = p;
    prev_h = h;
    for (int i = 0; i < p; i++) begin
      bus.div_clk_i = (i < h);
      bus.clr_err_i = clr && (i == 2);
      @(posedge clk);
      #1;
    end
    bus.clr_err_i = 1'b0;
  endtask

  task automatic stall(input int n);
    bus.div_clk_i = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    if (m_en) begin
      model_error();
      streak = 0;
      have_prev = 1'b0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_period"},  32'(bus.period_o), 0);
    chk({tag, "_high"},    32'(bus.high_o), 0);
    chk({tag, "_valid"},   32'(bus.meas_valid_o), 0);
    chk({tag, "_locked"},  32'(bus.locked_o), 0);
    chk({tag, "_err"},     32'(bus.err_o), 0);
    chk({tag, "_err_cnt"}, 32'(bus.err_cnt_o), 0);
  endtask

  always @(posedge clk) en_q <= bus.en_i;

  // Monitor: every measurement pulse must match the oldest predicted record
  always @(negedge clk) begin
    if (!rst && bus.meas_valid_o) begin
      if (sb_q.size() == 0) begin
        chk("spurious_meas_valid", 32'(bus.meas_valid_o), 0);
      end else begin
        meas_t e;
        e = sb_q.pop_front();
        chk("period",  32'(bus.period_o),  32'(e.period));
        chk("high",    32'(bus.high_o),    32'(e.high));
        chk("locked",  32'(bus.locked_o),  32'(e.locked));
        chk("err",     32'(bus.err_o),     32'(e.err));
        chk("err_cnt", 32'(bus.err_cnt_o), 32'(e.err_cnt));
      end
    end
    if (!rst && !en_q) chk("locked_while_disabled", 32'(bus.locked_o), 0);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p, h, len, nh;
    bit c;
    rst = 1'b1;
    bus.en_i = 1'b1;
    bus.div_clk_i = 1'b0;
    bus.clr_err_i = 1'b0;
    set_exp(4, 2);
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Nominal /4 lock
    repeat (7) drive_period(4, 2, 1'b0);
    chk("locked_after_nominal", 32'(bus.locked_o), 1);
    chk("err_after_nominal", 32'(bus.err_o), 0);

    // Expected period change while locked, then restore
    set_exp(6, 2);
    drive_period(4, 2, 1'b0);
    set_exp(4, 2);
    repeat (6) drive_period(4, 2, 1'b0);

    // Stuck-low clock while locked
    stall(300);
    chk("stall_err", 32'(bus.err_o), 1);
    chk("stall_err_cnt", 32'(bus.err_cnt_o), 32'(m_err_cnt));
    chk("stall_locked", 32'(bus.locked_o), 0);
    repeat (7) drive_period(4, 2, 1'b0);

    // Clear coinciding with a mismatch, then a lone clear
    set_exp(6, 2);
    drive_period(4, 2, 1'b1);
    set_exp(4, 2);
    drive_period(4, 2, 1'b0);
    drive_period(4, 2, 1'b1);
    chk("lone_clr_err", 32'(bus.err_o), 0);
    chk("lone_clr_cnt", 32'(bus.err_cnt_o), 0);
    repeat (5) drive_period(4, 2, 1'b0);

    // Enable dropped for 10 cycles while locked
    set_en(1'b0);
    drive_period(5, 2, 1'b0);
    drive_period(5, 3, 1'b0);
    set_en(1'b1);
    repeat (7) drive_period(4, 2, 1'b0);

    // Asynchronous reset mid-operation, between clock edges
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    have_prev = 1'b0;
    streak = 0;
    m_err = 1'b0;
    m_err_cnt = 0;
    @(posedge clk);
    #1;
    repeat (7) drive_period(4, 2, 1'b0);

    // Error counter saturation, then clear
    set_exp(6, 2);
    repeat (260) drive_period(4, 2, 1'b0);
    chk("err_cnt_saturated", 32'(bus.err_cnt_o), 255);
    set_exp(4, 2);
    drive_period(4, 2, 1'b1);

    // Randomized runs of assorted ratios with glitches, clears and enable drops
    for (int r = 0; r < 30; r++) begin
      p = $urandom_range(12, 4);
      h = $urandom_range(p - 2, 2);
      nh = (h == 2) ? 3 : h - 1;
      if ($urandom_range(3, 0) != 0) set_exp(p, h);
      else set_exp(p, nh);
      len = $urandom_range(8, 3);
      for (int k = 0; k < len; k++) begin
        c = ($urandom_range(7, 0) == 0);
        if ($urandom_range(9, 0) == 0) drive_period(p + 1, h, c);
        else drive_period(p, h, c);
      end
      if ($urandom_range(9, 0) == 0) begin
        set_en(1'b0);
        drive_period(6, 3, 1'b0);
        set_en(1'b1);
      end
    end

    drive_period(4, 2, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
